dma_c2h_desc_sched: RTL and testbench

Round-robin scheduler that shares one XDMA C2H descriptor-bypass channel among `NUM_REQ` requesters. Each accepted command (host address, byte length) is split into descriptors that never exceed `MAX_DESC_LEN` and never cross a `MAX_DESC_LEN`-aligned boundary. Descriptors are driven onto the `c2h_dsc_byp_*` port of one `dma_driver` channel. A credit counter bounds the number of in-flight descriptors. `dsc_req_id` tells the downstream C2H data mux which requester owns each issued descriptor.

---
 rtl/dma_c2h_desc_sched.sv | 166 ++++++++++++++++
 tb/tb_dma_c2h_desc_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_c2h_desc_sched.sv
// Round-robin scheduler sharing one XDMA C2H descriptor-bypass channel among NUM_REQ requesters.
// Commands are split into boundary-aligned descriptors; a credit counter bounds in-flight descriptors.
module dma_c2h_desc_sched #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_DESC_LEN    = 4096,
    parameter int MAX_OUTSTANDING = 8,
    localparam int IDW            = $clog2(NUM_REQ),
    localparam int OW             = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                     pcie_clk,
    input  logic                     pcie_rst,
    input  logic [NUM_REQ-1:0]       s_cmd_valid,
    output logic [NUM_REQ-1:0]       s_cmd_ready,
    input  logic [NUM_REQ-1:0][63:0] s_cmd_addr,
    input  logic [NUM_REQ-1:0][31:0] s_cmd_len,
    input  logic                     dsc_byp_ready,
    output logic                     dsc_byp_load,
    output logic [63:0]              dsc_byp_addr,
    output logic [31:0]              dsc_byp_len,
    output logic [IDW-1:0]           dsc_req_id,
    input  logic                     desc_cpl,
    output logic [NUM_REQ-1:0]       cmd_done,
    output logic [OW-1:0]            outstanding,
    output logic                     err_cpl_underflow
);

    localparam logic [OW-1:0] CREDITS = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

    // Start of the next descriptor to present and bytes left from there.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] rem;
    } pos_t;

    state_t             state, state_nxt;
    pos_t               pos, nxt_pos;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     win;
    logic               win_vld;
    int                 idx;
    logic               hs;
    logic               issue;
    logic               underflow;
    logic [OW-1:0]      out_nxt;
    logic [NUM_REQ-1:0] done_nxt;

    function automatic logic [31:0] chunk_of(input logic [63:0] a, input logic [31:0] r);
        logic [31:0] room;
        room = 32'(MAX_DESC_LEN) - (a[31:0] & 32'(MAX_DESC_LEN - 1));
        return (r < room) ? r : room;
    endfunction

    assign hs = dsc_byp_load & dsc_byp_ready;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && s_cmd_valid[idx]) begin
                win     = IDW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        s_cmd_ready = '0;
        if (state == IDLE && win_vld && !pcie_rst) s_cmd_ready[win] = 1'b1;
    end

    // A handshake and a completion in the same cycle cancel out.
    always_comb begin
        out_nxt   = outstanding;
        underflow = 1'b0;
        if (hs && !desc_cpl) begin
            out_nxt = outstanding + OW'(1);
        end else if (!hs && desc_cpl) begin
            if (outstanding == '0) underflow = 1'b1;
            else                   out_nxt   = outstanding - OW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        nxt_pos   = pos;
        done_nxt  = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    nxt_pos = '{addr: s_cmd_addr[win], rem: s_cmd_len[win]};
                    if (s_cmd_len[win] == '0) begin
                        done_nxt[win] = 1'b1;
                    end else if (outstanding < CREDITS) begin
                        state_nxt = ISSUE;
                        issue     = 1'b1;
                    end else begin
                        state_nxt = STALL;
                    end
                end
            end
            ISSUE: begin
                if (hs) begin
                    nxt_pos = '{addr: pos.addr + {32'b0, dsc_byp_len}, rem: pos.rem - dsc_byp_len};
                    if (nxt_pos.rem == '0) begin
                        done_nxt[dsc_req_id] = 1'b1;
                        state_nxt            = IDLE;
                    end else if (out_nxt == CREDITS) begin
                        state_nxt = STALL;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            STALL: begin
                if (outstanding < CREDITS) begin
                    state_nxt = ISSUE;
                    issue     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            pos               <= '0;
            rr_ptr            <= '0;
            dsc_byp_load      <= 1'b0;
            dsc_byp_addr      <= '0;
            dsc_byp_len       <= '0;
            dsc_req_id        <= '0;
            cmd_done          <= '0;
            outstanding       <= '0;
            err_cpl_underflow <= 1'b0;
        end else begin
            pos         <= nxt_pos;
            cmd_done    <= done_nxt;
            outstanding <= out_nxt;
            if (underflow) err_cpl_underflow <= 1'b1;
            // Descriptor outputs only change when a new descriptor is presented.
            if (issue) begin
                dsc_byp_load <= 1'b1;
                dsc_byp_addr <= nxt_pos.addr;
                dsc_byp_len  <= chunk_of(nxt_pos.addr, nxt_pos.rem);
            end else if (hs) begin
                dsc_byp_load <= 1'b0;
            end
            if (state == IDLE && win_vld) begin
                rr_ptr     <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
                dsc_req_id <= win;
            end
        end
    end

endmodule

// File: tb/tb_dma_c2h_desc_sched.sv
// Scoreboard bench for dma_c2h_desc_sched: a queue-based reference model predicts descriptors,
// grants, done pulses and credit count; a negedge monitor compares against the DUT.
module tb_dma_c2h_desc_sched;
    localparam int NUM_REQ = 4;
    localparam int MAXL    = 4096;
    localparam int MAXO    = 8;
    localparam int IDW     = 2;
    localparam int OW      = 4;

    logic                     pcie_clk = 1'b0;
    logic                     pcie_rst = 1'b1;
    logic [NUM_REQ-1:0]       s_cmd_valid = '0;
    logic [NUM_REQ-1:0]       s_cmd_ready;
    logic [NUM_REQ-1:0][63:0] s_cmd_addr = '0;
    logic [NUM_REQ-1:0][31:0] s_cmd_len = '0;
    logic                     dsc_byp_ready = 1'b0;
    logic                     dsc_byp_load;
    logic [63:0]              dsc_byp_addr;
    logic [31:0]              dsc_byp_len;
    logic [IDW-1:0]           dsc_req_id;
    logic                     desc_cpl = 1'b0;
    logic [NUM_REQ-1:0]       cmd_done;
    logic [OW-1:0]            outstanding;
    logic                     err_cpl_underflow;

    dma_c2h_desc_sched #(.NUM_REQ(NUM_REQ), .MAX_DESC_LEN(MAXL), .MAX_OUTSTANDING(MAXO)) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
        .dsc_byp_ready(dsc_byp_ready), .dsc_byp_load(dsc_byp_load),
        .dsc_byp_addr(dsc_byp_addr), .dsc_byp_len(dsc_byp_len), .dsc_req_id(dsc_req_id),
        .desc_cpl(desc_cpl), .cmd_done(cmd_done), .outstanding(outstanding),
        .err_cpl_underflow(err_cpl_underflow)
    );

    initial forever #5 pcie_clk = ~pcie_clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] l;
        int          id;
        bit          last;
    } desc_t;

    desc_t              exp_q[$];
    int                 grant_q[$];
    int                 checks = 0, failures = 0;
    int                 out_m = 0, rr_m = 0, hs_count = 0, done_count = 0;
    bit                 err_m = 0, load_exp = 0, held = 0;
    logic [NUM_REQ-1:0] done_exp = '0, acc_mask = '0, m_rdy;
    logic [63:0]        p_addr;
    logic [31:0]        p_len;
    logic [IDW-1:0]     p_id;
    int                 cpl_rate = 0, rdy_rate = 100;
    bit                 m_hs;
    int                 m_win, m_out_new;
    desc_t              m_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    // Reference split: walk the command in MAXL-aligned pieces.
    function automatic void push_cmd(int id, logic [63:0] a, logic [31:0] len);
        logic [63:0] cur, rem, c;
        cur = a;
        rem = {32'b0, len};
        while (rem != 0) begin
            c = 64'(MAXL) - (cur % 64'(MAXL));
            if (c > rem) c = rem;
            exp_q.push_back('{a: cur, l: c[31:0], id: id, last: (c == rem)});
            cur = cur + c;
            rem = rem - c;
        end
    endfunction

    always @(negedge pcie_clk) begin
        if (pcie_rst) begin
            exp_q.delete();
            out_m = 0; err_m = 0; done_exp = '0; load_exp = 0; rr_m = 0; held = 0; acc_mask = '0;
        end else begin
            m_hs = dsc_byp_load && dsc_byp_ready;
            chk("outstanding", outstanding, out_m);
            chk("err_cpl_underflow", err_cpl_underflow, err_m);
            chk("cmd_done", cmd_done, done_exp);
            chk("dsc_byp_load", dsc_byp_load, load_exp);
            if (held) begin
                chk("hold_addr", dsc_byp_addr, p_addr);
                chk("hold_len", dsc_byp_len, p_len);
                chk("hold_id", dsc_req_id, p_id);
            end
            if (load_exp && out_m >= MAXO) timeout("credit_overrun");
            m_win = -1;
            if (exp_q.size() == 0)
                for (int i = 0; i < NUM_REQ; i++)
                    if (m_win < 0 && s_cmd_valid[(rr_m + i) % NUM_REQ]) m_win = (rr_m + i) % NUM_REQ;
            m_rdy = '0;
            if (m_win >= 0) m_rdy[m_win] = 1'b1;
            chk("s_cmd_ready", s_cmd_ready, m_rdy);
            acc_mask = s_cmd_valid & s_cmd_ready;
            for (int i = 0; i < NUM_REQ; i++) if (cmd_done[i]) done_count++;

            done_exp = '0;
            if (m_hs) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    timeout("unexpected_descriptor");
                end else begin
                    m_d = exp_q.pop_front();
                    chk("desc_addr", dsc_byp_addr, m_d.a);
                    chk("desc_len", dsc_byp_len, m_d.l);
                    chk("desc_id", dsc_req_id, m_d.id);
                    if (m_d.last) done_exp[m_d.id] = 1'b1;
                end
            end
            m_out_new = out_m;
            if (m_hs && !desc_cpl) m_out_new = out_m + 1;
            else if (!m_hs && desc_cpl) begin
                if (out_m == 0) err_m = 1;
                else            m_out_new = out_m - 1;
            end
            if (m_win >= 0) begin
                grant_q.push_back(m_win);
                rr_m = (m_win + 1) % NUM_REQ;
                if (s_cmd_len[m_win] == 0) done_exp[m_win] = 1'b1;
                else                       push_cmd(m_win, s_cmd_addr[m_win], s_cmd_len[m_win]);
            end
            if (load_exp && !m_hs)  load_exp = 1;
            else if (m_hs)          load_exp = (exp_q.size() > 0) && (m_out_new < MAXO);
            else if (m_win >= 0)    load_exp = (s_cmd_len[m_win] != 0) && (out_m < MAXO);
            else                    load_exp = (exp_q.size() > 0) && (out_m < MAXO);
            held   = dsc_byp_load && !m_hs;
            p_addr = dsc_byp_addr;
            p_len  = dsc_byp_len;
            p_id   = dsc_req_id;
            out_m  = m_out_new;
        end
    end

    task automatic tick();
        @(posedge pcie_clk);
        #1;
        s_cmd_valid   = s_cmd_valid & ~acc_mask;
        desc_cpl      = (out_m > 0) && ($urandom_range(99) < cpl_rate);
        dsc_byp_ready = ($urandom_range(99) < rdy_rate);
    endtask

    task automatic issue(input int r, input logic [63:0] a, input logic [31:0] len);
        int n = 0;
        while (s_cmd_valid[r] && n < 5000) begin tick(); n++; end
        if (s_cmd_valid[r]) timeout("issue_wait");
        s_cmd_addr[r]  = a;
        s_cmd_len[r]   = len;
        s_cmd_valid[r] = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((s_cmd_valid != '0 || exp_q.size() != 0 || dsc_byp_load) && n < 5000) begin tick(); n++; end
        if (n >= 5000) timeout("wait_idle");
        tick(); tick();
    endtask

    task automatic drain();
        int n = 0;
        cpl_rate = 100;
        while (out_m != 0 && n < 100) begin tick(); n++; end
        if (out_m != 0) timeout("drain");
    endtask

    task automatic do_reset();
        pcie_rst = 1'b1; s_cmd_valid = '0; desc_cpl = 1'b0;
        tick(); tick();
        chk("rst_ready", s_cmd_ready, 0);
        chk("rst_load", dsc_byp_load, 0);
        chk("rst_addr", dsc_byp_addr, 0);
        chk("rst_len", dsc_byp_len, 0);
        chk("rst_id", dsc_req_id, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_cpl_underflow, 0);
        pcie_rst = 1'b0;
    endtask

    initial begin
        int base, dbase, len;
        logic [63:0] a;
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dbase;
        logic [63:0] a;
        logic [31:0] len;
        do_reset();

        // single descriptor
        cpl_rate = 0; rdy_rate = 100;
        base = hs_count; dbase = done_count;
        issue(0, 64'h1000, 32'h100);
        wait_idle();
        chk("single_count", hs_count - base, 1);
        chk("single_done", done_count - dbase, 1);
        chk("single_outstanding", outstanding, 1);

        // zero-length command
        base = hs_count; dbase = done_count;
        issue(1, 64'h0, 32'h0);
        wait_idle();
        chk("len0_count", hs_count - base, 0);
        chk("len0_done", done_count - dbase, 1);

        // boundary split
        base = hs_count;
        issue(2, 64'h0F00, 32'h2200);
        wait_idle();
        chk("split_count", hs_count - base, 4);
        drain();

        // credit stall
        cpl_rate = 0;
        base = hs_count;
        issue(0, 64'h0, 32'h10000);
        repeat (12) tick();
        chk("stall_outstanding", outstanding, MAXO);
        chk("stall_load", dsc_byp_load, 0);
        chk("stall_count", hs_count - base, 8);
        desc_cpl = 1'b1;
        repeat (3) tick();
        chk("stall_resume_outstanding", outstanding, MAXO);
        chk("stall_resume_count", hs_count - base, 9);
        cpl_rate = 60;
        wait_idle();
        drain();

        // backpressure with completions coinciding with handshakes
        rdy_rate = 100; cpl_rate = 100;
        issue(3, 64'h7F80, 32'h3000);
        tick(); tick();
        rdy_rate = 0;
        repeat (5) tick();
        rdy_rate = 100;
        wait_idle();
        drain();

        // underflow
        cpl_rate = 0;
        tick();
        desc_cpl = 1'b1;
        tick(); tick();
        chk("underflow_err", err_cpl_underflow, 1);

        // reset mid-split, then priority restarts at req0
        do_reset();
        cpl_rate = 0; rdy_rate = 100;
        issue(1, 64'h100, 32'h8000);
        repeat (4) tick();
        do_reset();
        grant_q.delete();
        issue(1, 64'h2000, 32'h40); issue(2, 64'h3000, 32'h40); issue(3, 64'h4000, 32'h40);
        wait_idle();
        chk("post_reset_grants", grant_q.size(), 3);
        if (grant_q.size() > 0) chk("post_reset_first", grant_q[0], 1);
        drain();

        // round-robin from reset
        do_reset();
        cpl_rate = 100;
        grant_q.delete();
        for (int r = 0; r < NUM_REQ; r++) issue(r, 64'(r) * 64'h1000, 32'h40);
        wait_idle();
        chk("rr_grants", grant_q.size(), 4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) chk("rr_order", grant_q[i], i);
        grant_q.delete();
        issue(1, 64'h5000, 32'h40); issue(3, 64'h6000, 32'h40);
        wait_idle();
        grant_q.delete();
        issue(0, 64'h8000, 32'h40); issue(1, 64'h9000, 32'h40); issue(3, 64'hA000, 32'h40);
        wait_idle();
        chk("rr2_grants", grant_q.size(), 3);
        if (grant_q.size() == 3) begin
            chk("rr2_0", grant_q[0], 0);
            chk("rr2_1", grant_q[1], 1);
            chk("rr2_2", grant_q[2], 3);
        end

        // randomized traffic
        rdy_rate = 70; cpl_rate = 40;
        for (int n = 0; n < 200; n++) begin
            a = {16'h0, 16'($urandom), $urandom};
            if ($urandom_range(1) == 0) a[11:0] = 12'hFFF - 12'($urandom_range(63));
            len = ($urandom_range(3) == 0) ? 32'($urandom_range(16)) : 32'($urandom_range(1, 32'h6000));
            issue($urandom_range(NUM_REQ - 1), a, len);
            repeat ($urandom_range(3)) tick();
        end
        wait_idle();
        drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
